fiapp_pipe: RTL
===============

Name: fiapp_pipe

Overview:
- Parametrised N-channel, W-bit, DEPTH-stage register pipeline with a built-in fault-injection controller and a signal-of-interest (SOI) observation port.
- Serves as the next-generation target block for the fault-injection app flow. It replaces fixed single-bit flops with configurable channels and stages, runtime bit-flip and stuck-at injection, and a registered SOI monitor for host-side sampling.

Parameters:
- N, 2, number of independent channels (>=1)
- W, 8, data width per channel (>=1)
- DEPTH, 3, pipeline stages per channel (>=2)
- DURW, 8, width of stuck-at duration field
- CNTW, 16, width of completed-injection counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- din  in  N*W  channel input data; channel c at bits [c*W +: W]
- en  in  N  per-channel load enable for stage 0
- dout  out  N*W  last-stage value per channel
- dout_n  out  N*W  registered complement of stage 0 per channel
- fi_req  in  1  injection request, level
- fi_chan  in  clog2(N) (min 1)  target channel
- fi_stage  in  clog2(DEPTH)  target stage
- fi_mask  in  W  bits to affect
- fi_mode  in  2  0=flip, 1=stuck-at-0, 2=stuck-at-1, 3=illegal
- fi_dur  in  DURW  stuck-at duration in cycles; 0 is treated as 1
- fi_ack  out  1  one-cycle acceptance/rejection pulse
- fi_err  out  1  valid with fi_ack; 1 = request rejected
- fi_busy  out  1  high while an injection is active
- fi_count  out  CNTW  saturating count of completed injections
- soi_chan  in  clog2(N) (min 1)  SOI channel select
- soi_stage  in  clog2(DEPTH)  SOI stage select
- soi_data  out  W  registered SOI sample
- soi_valid  out  1  SOI sample valid
- soi_chg  out  1  pulse: current sample differs from previous

Behaviour:
- Reset clears all of the following:
  - all stage registers, dout, dout_n and fi_count: 0
  - fi_ack, fi_err, fi_busy, soi_data, soi_valid, soi_chg: 0
  - FSM: IDLE
- Reset mid-injection aborts the injection and does not count it.
- Pipeline datapath:
  - Stage 0 next value D0 = en[c] ? din_c : s0_c.
  - Stage k>0 next value Dk = s(k-1)_c, loaded every cycle.
  - dout = s(DEPTH-1).
  - dout_n <= ~s0 each cycle.
  - With en held high, latency din->dout is DEPTH cycles and din->dout_n is 2 cycles.
- Fault FSM has two states, IDLE and ACTIVE.
- IDLE with fi_req=1:
  - All fi_* fields are validated in the same cycle.
  - The request is illegal if any of these holds: fi_chan>=N, fi_stage>=DEPTH, fi_mask==0, fi_mode==3.
  - Illegal request: next cycle fi_ack=1 and fi_err=1; FSM stays IDLE.
  - Legal request: all fields are latched; next cycle fi_ack=1, fi_err=0, FSM enters ACTIVE, and fi_busy=1.
  - The remaining counter loads max(fi_dur,1) for stuck modes and 1 for flip.
- ACTIVE:
  - Each cycle the target register's D is modified before capture.
  - Flip: D ^ mask.
  - Stuck-at-0: D & ~mask.
  - Stuck-at-1: D | mask.
  - The modification applies regardless of en (stage 0 with en=0 holds its value with forced bits).
  - The counter decrements each cycle. When it reaches 0 after the final modified cycle, the FSM returns to IDLE, fi_busy drops, and fi_count increments (saturating at all-ones).
- Timing of the first modified cycle: it is the cycle in which fi_ack is high, so the register shows the effect on the clock edge ending the ack cycle.
- fi_req while ACTIVE is ignored, with no ack.
- fi_req held high across completion is accepted on the first IDLE cycle.
- fi_ack is a one-cycle pulse only.
- Unaffected bits, channels and stages continue normal operation throughout an injection.
- SOI monitor:
  - soi_data <= s[soi_stage] of channel soi_chan every cycle (1-cycle latency).
  - Out-of-range selects sample 0.
  - soi_valid goes to 1 on the first clock after reset deasserts and stays high.
  - soi_chg = 1 when soi_valid was already high and the new sample != previous soi_data.

Test Plan:
- Reset, then N=2/W=8/DEPTH=3 with en=2'b11, din ch0=0xA5 and ch1=0x3C held -> dout ch0=0xA5 and ch1=0x3C on the 3rd edge; dout_n ch0=0x5A on the 2nd edge; soi (0,0) reads 0xA5 one cycle after stage 0 loads.
- Pipeline steady at 0xA5, flip on chan0/stage1 with mask=0x01 -> fi_ack=1 and fi_err=0 for 1 cycle; dout ch0 shows 0xA4 for exactly one cycle, then 0xA5; fi_count=1; ch1 unaffected.
- Stuck-at-1 on chan1/stage0 with mask=0x80, dur=4, en[1]=0 -> stage0 ch1 reads 0xBC for 4 cycles; fi_busy high 4 cycles; after release, stage 0 keeps 0xBC because en=0; fi_count increments by 1.
- Illegal requests fi_mode=3, then fi_stage=3, then fi_mask=0 -> each gives fi_ack=1 with fi_err=1, fi_busy stays 0, fi_count unchanged.
- fi_req asserted during an active dur=10 stuck-at-0 -> no ack until completion; ack on the first IDLE cycle; fi_count=2 after both finish. A second run uses dur=0 -> exactly one forced cycle.
- Reset asserted mid stuck-at (dur=200, cycle 5) -> all outputs 0 immediately, FSM IDLE, fi_count=0; soi_valid returns 1 one edge after release; soi_chg pulses on the first data change.

Source files
------------

// File: rtl/fiapp_pipe_if.sv
// fiapp_pipe_if: datapath, fault-injection and SOI signals of fiapp_pipe
interface fiapp_pipe_if #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int DEPTH = 3,
  parameter int DURW  = 8,
  parameter int CNTW  = 16
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int SW = $clog2(DEPTH);
  logic [N*W-1:0]  i_din;
  logic [N-1:0]    i_en;
  logic [N*W-1:0]  o_dout;
  logic [N*W-1:0]  o_dout_n;
  logic            i_fi_req;
  logic [CW-1:0]   i_fi_chan;
  logic [SW-1:0]   i_fi_stage;
  logic [W-1:0]    i_fi_mask;
  logic [1:0]      i_fi_mode;
  logic [DURW-1:0] i_fi_dur;
  logic            o_fi_ack;
  logic            o_fi_err;
  logic            o_fi_busy;
  logic [CNTW-1:0] o_fi_count;
  logic [CW-1:0]   i_soi_chan;
  logic [SW-1:0]   i_soi_stage;
  logic [W-1:0]    o_soi_data;
  logic            o_soi_valid;
  logic            o_soi_chg;
  modport master (
    output i_din, i_en, i_fi_req, i_fi_chan, i_fi_stage, i_fi_mask, i_fi_mode, i_fi_dur,
           i_soi_chan, i_soi_stage,
    input  o_dout, o_dout_n, o_fi_ack, o_fi_err, o_fi_busy, o_fi_count,
           o_soi_data, o_soi_valid, o_soi_chg
  );
  modport slave (
    input  i_din, i_en, i_fi_req, i_fi_chan, i_fi_stage, i_fi_mask, i_fi_mode, i_fi_dur,
           i_soi_chan, i_soi_stage,
    output o_dout, o_dout_n, o_fi_ack, o_fi_err, o_fi_busy, o_fi_count,
           o_soi_data, o_soi_valid, o_soi_chg
  );
endinterface

// File: rtl/fiapp_pipe.sv
// fiapp_pipe: N-channel DEPTH-stage pipeline with runtime flip/stuck-at injection and SOI monitor
module fiapp_pipe #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int DEPTH = 3,
  parameter int DURW  = 8,
  parameter int CNTW  = 16
) (
  input logic          clk,
  input logic          reset,
  fiapp_pipe_if.slave  p
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int SW = $clog2(DEPTH);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  logic [W-1:0]      r_s [N][DEPTH];
  logic [W-1:0]      w_d [N][DEPTH];
  logic [N*W-1:0]    r_dout_n;
  logic [N*W-1:0]    w_dout;
  logic [0:0]        r_state;
  logic [CW-1:0]     r_chan;
  logic [SW-1:0]     r_stage;
  logic [W-1:0]      r_mask;
  logic [1:0]        r_mode;
  logic [DURW-1:0]   r_cnt;
  logic [CNTW-1:0]   r_count;
  logic              r_ack;
  logic              r_err;
  logic              r_valid;
  logic              r_chg;
  logic [W-1:0]      r_soi;
  logic [W-1:0]      w_soi;
  logic [2**CW-1:0]  w_chan_ok;
  logic [2**SW-1:0]  w_stage_ok;
  logic              w_bad;
  // Legal-index tables avoid comparing narrow selects against out-of-range constants
  always_comb begin
    w_chan_ok = '0;
    w_stage_ok = '0;
    for (int i = 0; i < 2**CW; i++) w_chan_ok[i] = i < N;
    for (int i = 0; i < 2**SW; i++) w_stage_ok[i] = i < DEPTH;
  end
  assign w_bad = !w_chan_ok[p.i_fi_chan] || !w_stage_ok[p.i_fi_stage] ||
                 p.i_fi_mask == '0 || p.i_fi_mode == 2'd3;
  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_d[c][0] = p.i_en[c] ? p.i_din[c*W +: W] : r_s[c][0];
      for (int k = 1; k < DEPTH; k++) w_d[c][k] = r_s[c][k-1];
      for (int k = 0; k < DEPTH; k++)
        if (r_state == ACTIVE && r_chan == CW'(c) && r_stage == SW'(k))
          w_d[c][k] = r_mode == 2'd0 ? w_d[c][k] ^ r_mask :
                      r_mode == 2'd1 ? w_d[c][k] & ~r_mask : w_d[c][k] | r_mask;
    end
  end
  always_comb begin
    w_soi = '0;
    w_dout = '0;
    for (int c = 0; c < N; c++) begin
      w_dout[c*W +: W] = r_s[c][DEPTH-1];
      for (int k = 0; k < DEPTH; k++)
        if (p.i_soi_chan == CW'(c) && p.i_soi_stage == SW'(k)) w_soi = r_s[c][k];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int c = 0; c < N; c++)
        for (int k = 0; k < DEPTH; k++) r_s[c][k] <= '0;
      r_dout_n <= '0;
      r_state  <= IDLE;
      r_chan   <= '0;
      r_stage  <= '0;
      r_mask   <= '0;
      r_mode   <= '0;
      r_cnt    <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
      r_chg    <= 1'b0;
      r_soi    <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        for (int k = 0; k < DEPTH; k++) r_s[c][k] <= w_d[c][k];
        r_dout_n[c*W +: W] <= ~r_s[c][0];
      end
      r_ack   <= r_state == IDLE && p.i_fi_req;
      r_err   <= r_state == IDLE && p.i_fi_req && w_bad;
      r_valid <= 1'b1;
      r_soi   <= w_soi;
      r_chg   <= r_valid && w_soi != r_soi;
      if (r_state == IDLE) begin
        if (p.i_fi_req && !w_bad) begin
          r_state <= ACTIVE;
          r_chan  <= p.i_fi_chan;
          r_stage <= p.i_fi_stage;
          r_mask  <= p.i_fi_mask;
          r_mode  <= p.i_fi_mode;
          r_cnt   <= p.i_fi_mode == 2'd0 || p.i_fi_dur == '0 ? DURW'(1) : p.i_fi_dur;
        end
      end else begin
        r_cnt <= r_cnt - DURW'(1);
        if (r_cnt == DURW'(1)) begin
          r_state <= IDLE;
          r_count <= r_count + CNTW'(r_count != '1);
        end
      end
    end
  assign p.o_dout      = w_dout;
  assign p.o_dout_n    = r_dout_n;
  assign p.o_fi_ack    = r_ack;
  assign p.o_fi_err    = r_err;
  assign p.o_fi_busy   = r_state == ACTIVE;
  assign p.o_fi_count  = r_count;
  assign p.o_soi_data  = r_soi;
  assign p.o_soi_valid = r_valid;
  assign p.o_soi_chg   = r_chg;
endmodule
